// File: rtl/adc_capture_pkg.sv
// Shared types and defaults for the ADC capture block.
//   state_e       : capture FSM encoding, also driven on the state port
//   DECIM_MAX_DEF : default maximum log2 decimation
//   clamp_decim   : limits a requested decimation to the supported maximum
package adc_capture_pkg;

    localparam int unsigned DECIM_MAX_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_READOUT = 2'd3
    } state_e;

    function automatic int unsigned clamp_decim(input int unsigned d, input int unsigned dmax);
        return (d > dmax) ? dmax : d;
    endfunction

endpackage

// File: rtl/adc_capture_decim.sv
// Front end of the capture path: input registers, offset-binary to two's
// complement conversion, 2^d-sample box-car sum, floor shift and window
// overrange OR.
//   clk, rst_n           : clock, synchronous active-low reset
//   code                 : offset-binary ADC code, one per clk
//   ovfl_pos, ovfl_neg   : overrange flags aligned with code
//   clear                : restart the window with the next registered sample
//   d                    : log2 window length (already clamped)
//   dec_data, dec_ovfl   : decimated sample and its window overrange flag
//   dec_valid            : one-cycle pulse per completed window
module adc_decim
    import adc_capture_pkg::*;
#(
    parameter int unsigned BITS      = 8,
    parameter int unsigned DECIM_MAX = DECIM_MAX_DEF,
    parameter int unsigned DW        = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [BITS-1:0]        code,
    input  logic                   ovfl_pos,
    input  logic                   ovfl_neg,
    input  logic                   clear,
    input  logic [DW-1:0]          d,
    output logic signed [BITS-1:0] dec_data,
    output logic                   dec_ovfl,
    output logic                   dec_valid
);

    localparam int unsigned ACC_W = BITS + DECIM_MAX;
    localparam int unsigned CNT_W = (DECIM_MAX > 0) ? DECIM_MAX : 1;

    logic [BITS-1:0]          code_q, code_d;
    logic                     pos_q, pos_d;
    logic                     neg_q, neg_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     win_ovfl_q, win_ovfl_d;
    logic signed [BITS-1:0]   dec_data_q, dec_data_d;
    logic                     dec_ovfl_q, dec_ovfl_d;
    logic                     dec_valid_q, dec_valid_d;

    logic signed [BITS-1:0]   conv_c;
    logic signed [ACC_W-1:0]  conv_ext_c;
    logic signed [ACC_W-1:0]  sum_c;
    logic signed [ACC_W-1:0]  avg_c;
    logic [CNT_W-1:0]         win_len_m1_c;
    logic                     win_last_c;

    // Window accumulation; the completing sample is folded into the output
    // directly so the accumulator restarts at zero for the next window.
    always_comb begin
        code_d      = code;
        pos_d       = ovfl_pos;
        neg_d       = ovfl_neg;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        win_ovfl_d  = win_ovfl_q;
        dec_data_d  = dec_data_q;
        dec_ovfl_d  = dec_ovfl_q;
        dec_valid_d = 1'b0;

        conv_c       = {~code_q[BITS-1], code_q[BITS-2:0]};
        conv_ext_c   = {{DECIM_MAX{conv_c[BITS-1]}}, conv_c};
        sum_c        = acc_q + conv_ext_c;
        avg_c        = sum_c >>> d;
        win_len_m1_c = CNT_W'((32'd1 << d) - 32'd1);
        win_last_c   = (cnt_q == win_len_m1_c);

        if (clear) begin
            acc_d      = '0;
            cnt_d      = '0;
            win_ovfl_d = 1'b0;
        end else if (win_last_c) begin
            dec_valid_d = 1'b1;
            dec_data_d  = avg_c[BITS-1:0];
            dec_ovfl_d  = win_ovfl_q | pos_q | neg_q;
            acc_d       = '0;
            cnt_d       = '0;
            win_ovfl_d  = 1'b0;
        end else begin
            acc_d      = sum_c;
            cnt_d      = cnt_q + CNT_W'(1);
            win_ovfl_d = win_ovfl_q | pos_q | neg_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code_q      <= '0;
            pos_q       <= 1'b0;
            neg_q       <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            win_ovfl_q  <= 1'b0;
            dec_data_q  <= '0;
            dec_ovfl_q  <= 1'b0;
            dec_valid_q <= 1'b0;
        end else begin
            code_q      <= code_d;
            pos_q       <= pos_d;
            neg_q       <= neg_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            win_ovfl_q  <= win_ovfl_d;
            dec_data_q  <= dec_data_d;
            dec_ovfl_q  <= dec_ovfl_d;
            dec_valid_q <= dec_valid_d;
        end
    end

    assign dec_data  = dec_data_q;
    assign dec_ovfl  = dec_ovfl_q;
    assign dec_valid = dec_valid_q;

endmodule

// File: rtl/adc_capture.sv
// Triggered ADC capture: decimates the ADC stream, waits for a level crossing,
// stores DEPTH decimated samples in a RAM and streams them out.
//   clk, rst_n            : ADC clock, synchronous active-low reset
//   code, ovfl_pos/neg    : ADC code (offset binary) and overrange flags
//   arm, abort            : start request (IDLE only) / cancel to IDLE
//   decim                 : log2 averaging factor, latched on accepted arm
//   trig_level, trig_fall : signed threshold and edge select
//   out_data, out_ovfl    : captured sample and its window overrange flag
//   out_valid, out_ready  : readout handshake
//   state                 : current FSM state
module adc_capture
    import adc_capture_pkg::*;
#(
    parameter int unsigned BITS      = 8,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned DECIM_MAX = DECIM_MAX_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [BITS-1:0]                  code,
    input  logic                             ovfl_pos,
    input  logic                             ovfl_neg,
    input  logic                             arm,
    input  logic                             abort,
    input  logic [$clog2(DECIM_MAX+1)-1:0]   decim,
    input  logic signed [BITS-1:0]           trig_level,
    input  logic                             trig_fall,
    output logic signed [BITS-1:0]           out_data,
    output logic                             out_ovfl,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [1:0]                       state
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned DW = $clog2(DECIM_MAX + 1);
    localparam int unsigned MW = BITS + 1;

    state_e                  state_q, state_d;
    logic [DW-1:0]           d_q, d_d;
    logic signed [BITS-1:0]  prev_q, prev_d;
    logic                    have_prev_q, have_prev_d;
    logic [AW-1:0]           wr_addr_q, wr_addr_d;
    logic [AW:0]             rd_addr_q, rd_addr_d;
    logic                    out_valid_q, out_valid_d;
    logic [MW-1:0]           rd_data_q;

    logic signed [BITS-1:0]  dec_data;
    logic                    dec_ovfl;
    logic                    dec_valid;

    logic                    arm_ok_c;
    logic                    trig_hit_c;
    logic                    wr_en_c;
    logic [AW-1:0]           wr_idx_c;
    logic [MW-1:0]           wr_data_c;
    logic                    rd_en_c;
    logic [DW-1:0]           decim_clamped_c;

    logic [MW-1:0]           mem [DEPTH];

    adc_decim #(
        .BITS      (BITS),
        .DECIM_MAX (DECIM_MAX),
        .DW        (DW)
    ) u_decim (
        .clk       (clk),
        .rst_n     (rst_n),
        .code      (code),
        .ovfl_pos  (ovfl_pos),
        .ovfl_neg  (ovfl_neg),
        .clear     (arm_ok_c),
        .d         (d_q),
        .dec_data  (dec_data),
        .dec_ovfl  (dec_ovfl),
        .dec_valid (dec_valid)
    );

    // Next-state and datapath control for arm / trigger / capture / readout.
    always_comb begin
        state_d     = state_q;
        d_d         = d_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        out_valid_d = out_valid_q;
        arm_ok_c    = 1'b0;
        wr_en_c     = 1'b0;
        wr_idx_c    = wr_addr_q;
        wr_data_c   = {dec_ovfl, dec_data};
        rd_en_c     = 1'b0;

        decim_clamped_c = DW'(clamp_decim(32'(decim), DECIM_MAX));
        trig_hit_c = trig_fall ? ((prev_q > trig_level) && (dec_data <= trig_level))
                               : ((prev_q < trig_level) && (dec_data >= trig_level));

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    arm_ok_c    = 1'b1;
                    d_d         = decim_clamped_c;
                    prev_d      = '0;
                    have_prev_d = 1'b0;
                    state_d     = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (dec_valid) begin
                    // First sample after arm only seeds prev.
                    prev_d      = dec_data;
                    have_prev_d = 1'b1;
                    if (have_prev_q && trig_hit_c) begin
                        wr_en_c   = 1'b1;
                        wr_idx_c  = '0;
                        wr_addr_d = AW'(1);
                        state_d   = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (dec_valid) begin
                    wr_en_c   = 1'b1;
                    wr_addr_d = wr_addr_q + AW'(1);
                    if (wr_addr_q == AW'(DEPTH - 1)) begin
                        rd_addr_d = '0;
                        state_d   = ST_READOUT;
                    end
                end
            end
            ST_READOUT: begin
                // RAM read register doubles as the output stage: reload it
                // whenever it is empty or being consumed.
                if ((rd_addr_q != (AW+1)'(DEPTH)) && (!out_valid_q || out_ready)) begin
                    rd_en_c     = 1'b1;
                    rd_addr_d   = rd_addr_q + (AW+1)'(1);
                    out_valid_d = 1'b1;
                end else if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            arm_ok_c    = 1'b0;
            d_d         = d_q;
            wr_en_c     = 1'b0;
            rd_en_c     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            d_q         <= '0;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            d_q         <= d_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Capture buffer write port (contents are not reset).
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_idx_c] <= wr_data_c;
        end
    end

    // Synchronous read port feeding the output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en_c) begin
            rd_data_q <= mem[rd_addr_q[AW-1:0]];
        end
    end

    assign out_data  = rd_data_q[BITS-1:0];
    assign out_ovfl  = rd_data_q[BITS];
    assign out_valid = out_valid_q;
    assign state     = state_q;

endmodule

// File: tb/tb_adc_capture.sv
module tb_adc_capture;

    localparam int DEPTH = 16;
    localparam int DMAX  = 4;
    localparam int HMAX  = 65536;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        code = 8'h80;
    logic              ovfl_pos = 1'b0;
    logic              ovfl_neg = 1'b0;
    logic              arm = 1'b0;
    logic              abort = 1'b0;
    logic [2:0]        decim = 3'd0;
    logic signed [7:0] trig_level = 8'sd0;
    logic              trig_fall = 1'b0;
    logic signed [7:0] out_data;
    logic              out_ovfl;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [1:0]        state;

    adc_capture #(.BITS(8), .DEPTH(DEPTH), .DECIM_MAX(DMAX)) dut (
        .clk(clk), .rst_n(rst_n), .code(code), .ovfl_pos(ovfl_pos), .ovfl_neg(ovfl_neg),
        .arm(arm), .abort(abort), .decim(decim), .trig_level(trig_level),
        .trig_fall(trig_fall), .out_data(out_data), .out_ovfl(out_ovfl),
        .out_valid(out_valid), .out_ready(out_ready), .state(state)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   arm_seq = 0;
    int   done_cnt = 0;
    int   rmode = 0;
    int   m_a = 0, m_d = 0, m_lvl = 0;
    logic m_fall = 1'b0;
    logic [7:0] hist_code [HMAX];
    logic       hist_ov   [HMAX];
    int   exp_d [DEPTH];
    int   exp_o [DEPTH];
    int   exp_ok = 0;
    int   rcv_d [DEPTH];
    int   rcv_o [DEPTH];
    int   script [$];

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    function automatic int fdiv(input int s, input int n);
        int q;
        q = s / n;
        if (((s % n) != 0) && (s < 0)) q = q - 1;
        return q;
    endfunction

    // Reference: replay recorded ADC history from the arm cycle in windows of
    // 2^D samples, average with floor, search for the crossing, keep DEPTH.
    function automatic void build_exp();
        int n, w, sum, cur, prev, base;
        logic ov, have_prev, trig;
        n = 1 << m_d; w = 0; prev = 0; have_prev = 1'b0; trig = 1'b0;
        for (int k = 0; w < DEPTH; k++) begin
            base = m_a + k * n;
            if ((base + n > cyc) || (base + n > HMAX)) break;
            sum = 0; ov = 1'b0;
            for (int j = 0; j < n; j++) begin
                sum = sum + int'(hist_code[base + j]) - 128;
                ov  = ov | hist_ov[base + j];
            end
            cur = fdiv(sum, n);
            if (trig) begin
                exp_d[w] = cur; exp_o[w] = int'(ov); w++;
            end else if (!have_prev) begin
                prev = cur; have_prev = 1'b1;
            end else begin
                if (m_fall ? ((prev > m_lvl) && (cur <= m_lvl))
                           : ((prev < m_lvl) && (cur >= m_lvl))) begin
                    trig = 1'b1; exp_d[0] = cur; exp_o[0] = int'(ov); w = 1;
                end
                prev = cur;
            end
        end
        exp_ok = int'(w == DEPTH);
    endfunction

    // Input history recorder, indexed by clock edge.
    initial begin
        forever begin
            @(posedge clk);
            if (cyc < HMAX) begin
                hist_code[cyc] = code;
                hist_ov[cyc]   = ovfl_pos | ovfl_neg;
            end
            cyc = cyc + 1;
        end
    end

    // Output checker: every readout word against the model, stall stability,
    // first-word latency and post-stream idle.
    initial begin
        int idx = 0, seen = 0, ro_wait = 0, pd = 0, po = 0;
        logic built = 1'b0, pv = 1'b0, pr = 1'b0, post = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                idx = 0; built = 1'b0; pv = 1'b0; post = 1'b0; ro_wait = 0; seen = arm_seq;
                continue;
            end
            if (seen != arm_seq) begin
                seen = arm_seq; idx = 0; built = 1'b0;
            end
            if (post) begin
                chk("after_last_valid", int'(out_valid), 0);
                chk("after_last_state", int'(state), 0);
                post = 1'b0;
            end
            if (out_valid) begin
                if (!built) begin
                    build_exp();
                    built = 1'b1;
                    chk("model_has_full_capture", exp_ok, 1);
                    chk("first_valid_latency_le1", int'(ro_wait <= 1), 1);
                end
                if (pv && !pr) begin
                    chk("stall_data_stable", int'($signed(out_data)), pd);
                    chk("stall_ovfl_stable", int'(out_ovfl), po);
                end
                if (idx < DEPTH) begin
                    chk($sformatf("word_data[%0d]", idx), int'($signed(out_data)), exp_d[idx]);
                    chk($sformatf("word_ovfl[%0d]", idx), int'(out_ovfl), exp_o[idx]);
                    if (out_ready) begin
                        rcv_d[idx] = int'($signed(out_data));
                        rcv_o[idx] = int'(out_ovfl);
                        idx++;
                        if (idx == DEPTH) begin
                            done_cnt++;
                            post = 1'b1;
                        end
                    end
                end else begin
                    chk("extra_word_index", idx, DEPTH - 1);
                end
            end else if (pv && !pr) begin
                chk("stall_valid_held", int'(out_valid), 1);
            end
            if ((state == 2'd3) && !out_valid) ro_wait++;
            else ro_wait = 0;
            pv = out_valid; pr = out_ready;
            pd = int'($signed(out_data)); po = int'(out_ovfl);
        end
    end

    task automatic step(input logic a, input logic ab);
        int s;
        if (script.size() > 0) s = script.pop_front();
        else s = int'($urandom_range(0, 255))
               | ((($urandom_range(0, 15)) == 0) ? 256 : 0)
               | ((($urandom_range(0, 15)) == 0) ? 512 : 0);
        code = 8'(s); ovfl_pos = s[8]; ovfl_neg = s[9];
        arm = a; abort = ab;
        if (!a) decim = 3'($urandom_range(0, 7));
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        @(posedge clk); #1;
        arm = 1'b0; abort = 1'b0;
    endtask

    task automatic arm_cap(input int d, input int lvl, input logic fall);
        decim = 3'(d); trig_level = 8'(lvl); trig_fall = fall;
        m_d = (d > DMAX) ? DMAX : d; m_lvl = lvl; m_fall = fall; m_a = cyc;
        arm_seq++;
        step(1'b1, 1'b0);
    endtask

    task automatic load_ramp(input int ov_at);
        script.delete();
        for (int c = 8'h70; c <= 8'h9F; c++) script.push_back(c | ((c == ov_at) ? 256 : 0));
    endtask

    task automatic wait_state(input int st, input int budget);
        int n = 0;
        while ((int'(state) != st) && (n < budget)) begin
            step(1'b0, 1'b0); n++;
        end
        chk("reach_state", int'(state), st);
    endtask

    task automatic run_done(input int budget, input logic arm_ro);
        int start, n;
        logic did;
        start = done_cnt; n = 0; did = 1'b0;
        while ((done_cnt == start) && (n < budget)) begin
            if (arm_ro && !did && out_valid) begin
                step(1'b1, 1'b0); did = 1'b1;
                chk("arm_in_readout_ignored", int'(state), 3);
            end else begin
                step(1'b0, 1'b0);
            end
            n++;
        end
        chk("capture_done_in_budget", int'(done_cnt != start), 1);
        chk("idle_after_readout", int'(state), 0);
    endtask

    initial begin
        int ov_sum;
        // Reset values.
        rst_n = 1'b0;
        repeat (3) step(1'b0, 1'b0);
        chk("rst_state", int'(state), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'($signed(out_data)), 0);
        chk("rst_ovfl", int'(out_ovfl), 0);
        rst_n = 1'b1;
        step(1'b0, 1'b0);

        // Ramp, D=0, rising through 0.
        rmode = 0; load_ramp(-1); arm_cap(0, 0, 1'b0);
        run_done(400, 1'b0);
        for (int i = 0; i < DEPTH; i++) chk($sformatf("ramp_word[%0d]", i), rcv_d[i], i);
        for (int i = 0; i < DEPTH; i++) chk($sformatf("ramp_ovfl[%0d]", i), rcv_o[i], 0);

        // D=2 windows with floor on a negative average.
        script.delete();
        repeat (4) script.push_back(8'h7F);
        script.push_back(8'h80); script.push_back(8'h82);
        script.push_back(8'h84); script.push_back(8'h86);
        repeat (4) script.push_back(8'h7F);
        arm_cap(2, 1, 1'b0);
        run_done(1500, 1'b0);
        chk("d2_entry0", rcv_d[0], 3);
        chk("d2_entry1_floor", rcv_d[1], -1);

        // Single-cycle overrange lands in exactly one entry.
        load_ramp(8'h85); arm_cap(0, 0, 1'b0);
        run_done(400, 1'b0);
        ov_sum = 0;
        for (int i = 0; i < DEPTH; i++) ov_sum += rcv_o[i];
        chk("ovfl_entry5", rcv_o[5], 1);
        chk("ovfl_count", ov_sum, 1);

        // Falling edge at level 10.
        script.delete();
        script.push_back(8'h80 + 20); script.push_back(8'h80 + 15); script.push_back(8'h80 + 10);
        arm_cap(0, 10, 1'b1);
        run_done(400, 1'b0);
        chk("fall_entry0", rcv_d[0], 10);

        // Readout with out_ready toggling.
        rmode = 1; load_ramp(-1); arm_cap(0, 0, 1'b0);
        run_done(400, 1'b0);
        for (int i = 0; i < DEPTH; i++) chk($sformatf("stall_word[%0d]", i), rcv_d[i], i);
        rmode = 0;

        // Abort on the fifth capture cycle, re-arm, arm ignored in readout.
        load_ramp(-1); arm_cap(0, 0, 1'b0);
        wait_state(2, 200);
        repeat (4) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("abort_state", int'(state), 0);
        chk("abort_valid", int'(out_valid), 0);
        step(1'b0, 1'b0);
        chk("abort_stays_idle", int'(state), 0);
        load_ramp(-1); arm_cap(0, 0, 1'b0);
        run_done(400, 1'b1);
        for (int i = 0; i < DEPTH; i++) chk($sformatf("rearm_word[%0d]", i), rcv_d[i], i);

        // Reset in the middle of a capture.
        load_ramp(-1); arm_cap(0, 0, 1'b0);
        wait_state(2, 200);
        rst_n = 1'b0;
        step(1'b0, 1'b0);
        chk("midrst_state", int'(state), 0);
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_data", int'($signed(out_data)), 0);
        rst_n = 1'b1;
        step(1'b0, 1'b0);

        // Randomized captures (decim up to 7 exercises the clamp).
        rmode = 2;
        for (int t = 0; t < 6; t++) begin
            script.delete();
            arm_cap(int'($urandom_range(0, 7)), int'($urandom_range(0, 40)) - 20,
                    1'($urandom_range(0, 1)));
            run_done(5000, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_capture.md
ADC_CAPTURE -- requirements
Module: adc_capture

Interface
REQ-001 Parameter BITS, default 8: ADC code width.
REQ-002 Parameter DEPTH, default 256: capture buffer entries (power of 2).
REQ-003 Parameter DECIM_MAX, default 4: maximum log2 decimation.
REQ-004 Single clock domain; reset synchronous, active-low.
REQ-005 clk  in  1  sample clock, same as the ADC clock.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 code  in  BITS  offset-binary ADC code, one per clk.
REQ-008 ovfl_pos / ovfl_neg  in  1 each  ADC overrange flags, aligned with code.
REQ-009 arm  in  1  start request, single-cycle pulse.
REQ-010 abort  in  1  cancel any operation.
REQ-011 decim  in  $clog2(DECIM_MAX+1)  log2 averaging factor.
REQ-012 trig_level  in  BITS  signed trigger threshold.
REQ-013 trig_fall  in  1  0 = rising edge, 1 = falling edge.
REQ-014 out_data  out  BITS  signed captured sample.
REQ-015 out_ovfl  out  1  overrange seen in that sample's window.
REQ-016 out_valid  out  1 / out_ready  in  1  readout stream handshake.
REQ-017 state  out  2  current FSM state.

Function
REQ-018 Conversion SHALL invert the code MSB: offset binary to two's complement (0x80 -> 0, 0xFF -> 127, 0x00 -> -128).
REQ-019 Inputs SHALL be registered once before any other use.
REQ-020 Decimator SHALL sum 2^D consecutive converted samples in a signed accumulator of BITS+DECIM_MAX bits.
REQ-021 Decimator SHALL output the sum arithmetically shifted right by D (floor) and pulse dec_valid once per window.
REQ-022 D = decim, latched on accepted arm; decim SHALL be ignored at all other times; values above DECIM_MAX SHALL clamp.
REQ-023 Window overflow SHALL be the OR of (ovfl_pos|ovfl_neg) across the window.
REQ-024 Accepted arm SHALL clear the accumulator, so the first window begins with the next registered sample.
REQ-025 Latency with D=0: code at cycle n SHALL give dec_valid at cycle n+2.
REQ-026 FSM states: IDLE=0, ARMED=1, CAPTURE=2, READOUT=3.
REQ-027 IDLE -> ARMED on arm; arm SHALL be ignored in any other state.
REQ-028 In ARMED, the trigger SHALL compare each decimated sample (cur) with the previous one (prev).
REQ-029 Rising trigger: prev < trig_level and cur >= trig_level; falling trigger: prev > trig_level and cur <= trig_level.
REQ-030 The first decimated sample after arm SHALL NOT trigger; it only loads prev.
REQ-031 On trigger, cur SHALL be written to address 0 and the FSM SHALL enter CAPTURE.
REQ-032 CAPTURE SHALL write the next DEPTH-1 decimated samples to consecutive addresses, then enter READOUT.
REQ-033 READOUT SHALL present entries 0..DEPTH-1 in order; each transfer occurs when out_valid and out_ready are both high.
REQ-034 While out_valid=1 and out_ready=0, out_data and out_ovfl SHALL hold stable.
REQ-035 First out_valid SHALL assert within 2 cycles of entering READOUT; there SHALL be no bubbles while out_ready=1.
REQ-036 After the DEPTH-th transfer: out_valid=0 next cycle; state=IDLE.
REQ-037 abort SHALL force IDLE and out_valid=0 on the next cycle from any state; abort wins over a simultaneous arm.
REQ-038 Buffer contents after abort are don't-care; a new arm SHALL work normally.

Reset
REQ-039 While rst_n=0 at a clock edge: state=IDLE, out_valid=0, out_data=0, out_ovfl=0, accumulator/counters/prev=0, latched D=0.
REQ-040 Reset mid-capture or mid-readout SHALL discard the operation; RAM contents need not be cleared.

Structure
REQ-041 Package adc_capture_pkg SHALL hold the state enum and the default DECIM_MAX.
REQ-042 Sub-module adc_decim SHALL contain conversion, accumulator, shift and ovfl OR.
REQ-043 Buffer SHALL be an inferred single-clock RAM, DEPTH x (BITS+1), with synchronous read.

Verification (BITS=8, DEPTH=16)
REQ-044 D=0, level=0, rising; ramp code 0x70..0x9F -> 16 words 0,1,...,15, all out_ovfl=0, then state=0.
REQ-045 D=2; windows 0x80,0x82,0x84,0x86 -> sample 3; window 0x7F x4 -> -1 (floor); captured values match.
REQ-046 D=0; ovfl_pos high for one cycle during capture -> exactly that entry has out_ovfl=1.
REQ-047 Falling trigger, level=10, samples 20,15,10 -> entry 0 = 10.
REQ-048 out_ready toggling 1/0 during readout -> 16 words in order, none duplicated or dropped, data stable while stalled.
REQ-049 abort on 5th capture cycle -> state=0 and out_valid=0 next cycle; re-arm then completes a normal capture; arm during READOUT is ignored.
